// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender with registered output stage and one-entry skid buffer.
//   Ports: clk, reset (async active-low), flush (sync pipeline flush),
//          in_valid/in_ready/in_imm/in_op/in_tag (input handshake),
//          out_valid/out_ready/out_data/out_tag (output handshake),
//          out_err (reserved-opcode flag, only when EXT_ERR_EN is defined).
//   Opcodes: 000 zero-ext, 001 sign-ext, 010 upper, 011 sign-ext << 2, 1xx reserved.
//   Macro EXT_ERR_EN: reserved opcodes yield data 0 with out_err=1; otherwise they zero-extend.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef EXT_ERR_EN
  ,
  output logic              out_err
`endif
);
  logic [DATA_W-1:0] zx, sx, up, ext, sk_data;
  logic [TAG_W-1:0] sk_tag;
  logic sk_valid, acc, xfer;
`ifdef EXT_ERR_EN
  logic sk_err;
`endif
  assign zx = DATA_W'(in_imm);
  assign sx = DATA_W'($signed(in_imm));
  assign up = zx << (DATA_W - IMM_W);
`ifdef EXT_ERR_EN
  assign ext = in_op[2] ? '0 : in_op[1] ? (in_op[0] ? sx << 2 : up) : (in_op[0] ? sx : zx);
`else
  assign ext = in_op[2] ? zx : in_op[1] ? (in_op[0] ? sx << 2 : up) : (in_op[0] ? sx : zx);
`endif
  // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally
  assign in_ready = !sk_valid;
  assign acc = in_valid && !sk_valid;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      sk_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
      sk_data <= '0;
      sk_tag <= '0;
`ifdef EXT_ERR_EN
      out_err <= 1'b0;
      sk_err <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (acc && (!out_valid || xfer)) begin
      out_valid <= 1'b1;
      out_data <= ext;
      out_tag <= in_tag;
`ifdef EXT_ERR_EN
      out_err <= in_op[2];
`endif
    end else if (acc) begin
      sk_valid <= 1'b1;
      sk_data <= ext;
      sk_tag <= in_tag;
`ifdef EXT_ERR_EN
      sk_err <= in_op[2];
`endif
    end else if (xfer) begin
      out_valid <= sk_valid;
      sk_valid <= 1'b0;
      if (sk_valid) begin
        out_data <= sk_data;
        out_tag <= sk_tag;
`ifdef EXT_ERR_EN
        out_err <= sk_err;
`endif
      end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed and randomized self-checking bench for ext_pipe against a queue model.
module tb_ext_pipe;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_imm = '0;
  logic [2:0] in_op = '0;
  logic [31:0] in_tag = '0;
  logic in_ready, out_valid;
  logic [31:0] out_data, out_tag;
`ifdef EXT_ERR_EN
  logic out_err;
`endif
  int checks = 0, errors = 0, n_acc = 0;
  typedef struct {logic [31:0] d; logic [31:0] t; logic e;} ent_t;
  ent_t q[$];
  logic stall = 0, m_acc, m_xfer;
  logic [31:0] stall_d = '0;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef EXT_ERR_EN
    , .out_err(out_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
    end
  endfunction

  function automatic ent_t ref_ext(logic [2:0] op, logic [15:0] imm, logic [31:0] tag);
    ent_t r;
    int s;
    s = int'($signed(imm));
    r.t = tag;
    r.e = 1'b0;
    case (op)
      3'd0: r.d = 32'(imm);
      3'd1: r.d = s;
      3'd2: r.d = 32'(imm) * 65536;
      3'd3: r.d = s * 4;
      default: begin
`ifdef EXT_ERR_EN
        r.d = 32'h0;
        r.e = 1'b1;
`else
        r.d = 32'(imm);
`endif
      end
    endcase
    return r;
  endfunction

  always @(negedge reset) begin
    q.delete();
    stall = 1'b0;
  end

  always @(posedge clk)
    if (reset) begin
      stall = out_valid && !out_ready;
      stall_d = out_data;
      if (flush) q.delete();
      else begin
        m_acc = in_valid && q.size() < 2;
        m_xfer = q.size() > 0 && out_ready;
        if (m_xfer) void'(q.pop_front());
        if (m_acc) begin
          q.push_back(ref_ext(in_op, in_imm, in_tag));
          n_acc++;
        end
      end
    end

  always @(negedge clk)
    if (reset) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", out_tag, q[0].t);
`ifdef EXT_ERR_EN
        chk("out_err", out_err, q[0].e);
`endif
        if (stall) chk("stall_stable", out_data, stall_d);
      end
    end

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] imm, input logic [31:0] tag);
    in_valid = v;
    in_op = op;
    in_imm = imm;
    in_tag = tag;
  endtask

  logic [31:0] mexp [4] = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010};
  int cyc = 0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
`ifdef EXT_ERR_EN
    chk("rst_out_err", out_err, 0);
`endif
    #1 reset = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 16'h8004, 32'hA000 + i);
      @(negedge clk);
      chk("mode_valid", out_valid, 1);
      chk("mode_data", out_data, mexp[i]);
      chk("mode_tag", out_tag, 32'hA000 + i);
    end
    in_valid = 0;
    @(negedge clk);
    drive(1, 3'b101, 16'h1234, 32'hBEEF);
    @(negedge clk);
    in_valid = 0;
`ifdef EXT_ERR_EN
    chk("rsv_data", out_data, 32'h0);
    chk("rsv_err", out_err, 1);
`else
    chk("rsv_data", out_data, 32'h00001234);
`endif
    @(negedge clk);
    out_ready = 0;
    drive(1, 0, 16'd1, 32'd1);
    @(negedge clk);
    chk("bp_first", out_data, 1);
    drive(1, 0, 16'd2, 32'd2);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold1", out_data, 1);
    drive(1, 0, 16'd3, 32'd3);
    @(negedge clk);
    chk("bp_hold2", out_data, 1);
    chk("bp_in_ready_still_low", in_ready, 0);
    out_ready = 1;
    @(negedge clk);
    chk("bp_out2", out_data, 2);
    chk("bp_in_ready_rise", in_ready, 1);
    @(negedge clk);
    chk("bp_out3", out_data, 3);
    drive(1, 0, 16'd4, 32'd4);
    @(negedge clk);
    chk("bp_out4", out_data, 4);
    in_valid = 0;
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    out_ready = 0;
    drive(1, 0, 16'd5, 32'd5);
    @(negedge clk);
    drive(1, 0, 16'd6, 32'd6);
    @(negedge clk);
    chk("fl_or5", out_data, 5);
    drive(1, 0, 16'd7, 32'd7);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    drive(1, 0, 16'd8, 32'd8);
    out_ready = 1;
    @(negedge clk);
    chk("fl_next8", out_data, 8);
    in_valid = 0;
    @(negedge clk);
    chk("fl_no7", out_valid, 0);
    out_ready = 0;
    drive(1, 0, 16'd9, 32'd9);
    @(negedge clk);
    drive(1, 0, 16'd10, 32'd10);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    #1 reset = 1;
    drive(1, 3'd1, 16'hFFFF, 32'h77);
    @(negedge clk);
    chk("mrst_post_data", out_data, 32'hFFFFFFFF);
    chk("mrst_post_tag", out_tag, 32'h77);
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    n_acc = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_op = 3'($urandom);
      in_imm = 16'($urandom);
      in_tag = $urandom;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 2;
      cyc++;
      @(negedge clk);
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    repeat (3) @(negedge clk);
    chk("random_count", n_acc >= 10000, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
